// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// One requester's connection to the shared-memory arbiter.
//
// Signals (all on the arbiter's clock):
//   req    requester -> arbiter  access request, held with addr/we/wdata until gnt
//   lock   requester -> arbiter  keep bus ownership after the current transfer
//   we     requester -> arbiter  1 = write, 0 = read
//   addr   requester -> arbiter  16-bit address (arbiter uses the low bits only)
//   wdata  requester -> arbiter  write data
//   gnt    arbiter -> requester  combinational grant; a transfer happens on req&gnt
//   rvalid arbiter -> requester  one-cycle pulse, one cycle after a granted read
//   rdata  arbiter -> requester  registered read data, held until the next read
//
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int DATA_W = 16
) ();
  logic              req;
  logic              lock;
  logic              we;
  logic [15:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares a single-port memory (asynchronous read, synchronous write) between
// two requesters: port 0 (CPU) and port 1 (loader / DMA). Round-robin on ties,
// a per-port bus lock for atomic sequences, and a starvation guard that breaks
// a lock after MAX_HOLD consecutive cycles of holding off the other port.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-high reset
//   p0, p1     requester interfaces (slave modport), see mem_arbiter_if
//   mem_addr   memory address (0 when no transfer)
//   mem_we     memory write enable, only ever high together with a grant
//   mem_wdata  memory write data (0 when no transfer)
//   mem_rdata  asynchronous read data for mem_addr
//   owner      lock status: 00 none, 01 port0 locked, 10 port1 locked
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      p0,
  mem_arbiter_if.slave      p1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_P0   = 2'b01,
    OWN_P1   = 2'b10
  } owner_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  owner_t     owner_reg;
  logic       last_winner_reg;   // 0 = port0 won last, 1 = port1 won last
  logic [7:0] hold_cnt_reg;

  logic [1:0] req;
  logic [1:0] lock;
  logic [1:0] we;
  logic [1:0] gnt;
  logic       contended;
  logic       preempt;

  // Upper requester address bits are deliberately ignored.
  logic [2*(16-ADDR_W)-1:0] unused_addr_bits;
  assign unused_addr_bits = {p1.addr[15:ADDR_W], p0.addr[15:ADDR_W]};

  assign req  = {p1.req,  p0.req};
  assign lock = {p1.lock, p0.lock};
  assign we   = {p1.we,   p0.we};

  // The lock holder is keeping the other port waiting this cycle.
  assign contended = ((owner_reg == OWN_P0) && req[1]) ||
                     ((owner_reg == OWN_P1) && req[0]);

  // Lock has held off the other port long enough: hand it this cycle.
  assign preempt = contended && (hold_cnt_reg == HOLD_LIMIT);

  // Grant decision. A grant is only ever given to a requesting port, so
  // gnt[i] alone marks a transfer by port i.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (owner_reg)
        OWN_P0:  gnt = preempt ? 2'b10 : {1'b0, req[0]};
        OWN_P1:  gnt = preempt ? 2'b01 : {req[1], 1'b0};
        default: begin
          if (&req) begin
            gnt = last_winner_reg ? 2'b01 : 2'b10;
          end else begin
            gnt = req;
          end
        end
      endcase
    end
  end

  assign p0.gnt = gnt[0];
  assign p1.gnt = gnt[1];

  // Memory drive follows the granted port; idle bus presents zeros.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_addr  = p0.addr[ADDR_W-1:0];
      mem_we    = p0.we;
      mem_wdata = p0.wdata;
    end else if (gnt[1]) begin
      mem_addr  = p1.addr[ADDR_W-1:0];
      mem_we    = p1.we;
      mem_wdata = p1.wdata;
    end
  end

  // Ownership FSM, round-robin pointer and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg       <= OWN_NONE;
      last_winner_reg <= 1'b1;
      hold_cnt_reg    <= 8'd0;
    end else begin
      if (|gnt) begin
        last_winner_reg <= gnt[1];
      end

      if (contended && !preempt) begin
        hold_cnt_reg <= hold_cnt_reg + 8'd1;
      end else begin
        hold_cnt_reg <= 8'd0;
      end

      case (owner_reg)
        OWN_NONE: begin
          if (gnt[0] && lock[0]) begin
            owner_reg <= OWN_P0;
          end else if (gnt[1] && lock[1]) begin
            owner_reg <= OWN_P1;
          end
        end
        // Release happens whenever the holder drops lock, even while idle.
        OWN_P0: begin
          if (preempt || !lock[0]) begin
            owner_reg <= OWN_NONE;
          end
        end
        OWN_P1: begin
          if (preempt || !lock[1]) begin
            owner_reg <= OWN_NONE;
          end
        end
        default: owner_reg <= OWN_NONE;
      endcase
    end
  end

  assign owner = owner_reg;

  // Per-port read return: capture on the granted read, pulse rvalid next cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= gnt[gi] && !we[gi];
        if (gnt[gi] && !we[gi]) begin
          rdata_reg <= mem_rdata;
        end
      end
    end
  end

  // Reset cancels a read return that is already in flight.
  assign p0.rvalid = g_ret[0].rvalid_reg && !rst;
  assign p1.rvalid = g_ret[1].rvalid_reg && !rst;
  assign p0.rdata  = g_ret[0].rdata_reg;
  assign p1.rdata  = g_ret[1].rdata_reg;

endmodule
